lutram_fifo: RTL

Synchronous first-word-fall-through FIFO built on a distributed (LUT) RAM array, parametrised in data width and depth. It adds pointer management, fill tracking, programmable almost-full/almost-empty thresholds and sticky error flags on top of plain async-read LUT RAM. It is intended for shallow buffering between bus/peripheral stages in a single clock domain.

---
 rtl/lutram_fifo_if.sv | 33 +++
 rtl/lutram_fifo.sv | 103 ++++++++++
 2 files changed

// File: rtl/lutram_fifo_if.sv
// lutram_fifo_if: handshake/data bundle between a FIFO user and lutram_fifo.
//   master modport - the user side. It drives push/pushData/pop/clearErrors and
//                    observes the head data, the level, the flags and the errors.
//   slave modport  - the FIFO side. It is the mirror of the master modport.
interface lutram_fifo_if #(
  parameter int nrOfAddressBits = 5,
  parameter int nrOfDataBits    = 32
);
  logic                      push;
  logic [nrOfDataBits-1:0]   pushData;
  logic                      pop;
  logic [nrOfDataBits-1:0]   popData;
  logic                      full;
  logic                      empty;
  logic                      almostFull;
  logic                      almostEmpty;
  logic [nrOfAddressBits:0]  fillLevel;
  logic                      overflow;
  logic                      underflow;
  logic                      clearErrors;

  modport master (
    output push, pushData, pop, clearErrors,
    input  popData, full, empty, almostFull, almostEmpty, fillLevel,
           overflow, underflow
  );

  modport slave (
    input  push, pushData, pop, clearErrors,
    output popData, full, empty, almostFull, almostEmpty, fillLevel,
           overflow, underflow
  );
endinterface

// File: rtl/lutram_fifo.sv
// lutram_fifo: single-clock first-word-fall-through FIFO on an async-read
// LUT RAM. The head entry is always presented on popData, so a read costs
// no latency. The design also provides a fill counter, programmable
// almost-full/almost-empty thresholds, and sticky overflow/underflow flags.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high. It clears the pointers, the level and
//           the error flags. RAM contents are kept.
//   bus   - lutram_fifo_if.slave: push/pushData, pop/popData, full, empty,
//           almostFull, almostEmpty, fillLevel, overflow, underflow, clearErrors
module lutram_fifo #(
  parameter int nrOfAddressBits  = 5,
  parameter int nrOfDataBits     = 32,
  parameter int almostFullLevel  = 2**nrOfAddressBits - 2,
  parameter int almostEmptyLevel = 2
) (
  input  logic         clock,
  input  logic         reset,
  lutram_fifo_if.slave bus
);
  localparam int AW    = nrOfAddressBits;
  localparam int DW    = nrOfDataBits;
  localparam int DEPTH = 2**AW;

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(almostFullLevel);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(almostEmptyLevel);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full_w, empty_w, push_ok, pop_ok;

  // All flags are decoded from the registered level. They therefore follow
  // the causing edge by one cycle.
  assign full_w  = (fill_q == DEPTH_LVL);
  assign empty_w = (fill_q == '0);

  assign pop_ok  = bus.pop & ~empty_w;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok = bus.push & (~full_w | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase

    // A new error event outranks clearErrors, so no event is lost.
    if (bus.clearErrors) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.push & ~push_ok)  overflow_d  = 1'b1;
    if (bus.pop  & empty_w)   underflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The RAM is never reset. A push that coincides with reset is dropped, so
  // the RAM stays consistent with the cleared pointers.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem[wr_ptr_q] <= bus.pushData;
  end

  assign bus.popData     = mem[rd_ptr_q];
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostFull  = (fill_q >= AF_LVL);
  assign bus.almostEmpty = (fill_q <= AE_LVL);
  assign bus.fillLevel   = fill_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule
